// File: rtl/fsm_seq1011_3alw.sv
// Serial "1011" pattern detector with overlap.
// Moore machine split into three processes: state register, next-state logic
// and output decode.
//
// Ports:
//   clk - system clock; all state changes on the rising edge
//   clr - synchronous, active-high reset to S0
//   x   - serial data bit, consumed every cycle
//   z   - detect flag, high for one cycle after the final 1 of "1011"
module fsm_seq1011_3alw (
  input  logic clk,
  input  logic clr,
  input  logic x,
  output logic z
);

  typedef enum logic [2:0] {
    S0 = 3'b000,  // idle, no prefix matched
    S1 = 3'b001,  // seen 1
    S2 = 3'b010,  // seen 10
    S3 = 3'b011,  // seen 101
    S4 = 3'b100   // seen 1011
  } state_e;

  state_e state_q;
  state_e state_d;

  // State register; clr overrides every transition.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. From S4 the matched suffix is reused so that
  // overlapping occurrences are caught; unused codes fall back to S0.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = x ? S1 : S0;
      S1:      state_d = x ? S1 : S2;
      S2:      state_d = x ? S3 : S0;
      S3:      state_d = x ? S4 : S2;
      S4:      state_d = x ? S1 : S2;
      default: state_d = S0;
    endcase
  end

  // Moore decode from the state register only; x never reaches z directly.
  always_comb begin
    z = (state_q == S4);
  end

endmodule

// File: tb/tb_fsm_seq1011_3alw.sv
// Testbench for fsm_seq1011_3alw: a vector table for reset and the main
// stream, plus hand-written sequences checked against a shift-history model.
module tb_fsm_seq1011_3alw;

  logic clk;
  logic clr;
  logic x;
  logic z;

  fsm_seq1011_3alw dut (
    .clk (clk),
    .clr (clr),
    .x   (x),
    .z   (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic clr;
    logic x;
    logic z_exp;
  } vec_t;

  typedef struct {
    string name;
    logic  z_exp;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;
  logic [3:0] hist;

  // Reference model: last four bits accepted since the most recent clear.
  task automatic model_step(input logic c, input logic xi, output logic ez);
    if (c) begin
      hist = 4'b0000;
    end else begin
      hist = {hist[2:0], xi};
    end
    ez = (!c) && (hist == 4'b1011);
  endtask

  // Pop the oldest expectation and compare it with the DUT output.
  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: z=%b with no expected value queued", z);
    end else begin
      e = exp_q.pop_front();
      n_tests++;
      if (z !== e.z_exp) begin
        n_fail++;
        $display("FAIL %s: z=%b expected %b (t=%0t)", e.name, z, e.z_exp, $time);
      end
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic drive(input logic c, input logic xi, input logic ez, input string name);
    exp_t e;
    @(negedge clk);
    clr = c;
    x   = xi;
    e.name  = name;
    e.z_exp = ez;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic drive_model(input logic c, input logic xi, input string name);
    logic ez;
    model_step(c, xi, ez);
    drive(c, xi, ez, name);
  endtask

  // Feed a string of '0'/'1' characters through the model-checked path.
  task automatic send_str(input string s, input string name);
    for (int i = 0; i < s.len(); i++) begin
      drive_model(1'b0, (s[i] == 8'h31), $sformatf("%s[%0d]", name, i + 1));
    end
  endtask

  function automatic void add_vec(input logic c, input logic xi, input logic ez);
    vec_t v;
    v.clr   = c;
    v.x     = xi;
    v.z_exp = ez;
    vecs.push_back(v);
  endfunction

  initial begin
    string main_bits;
    string pulse_bits;
    n_tests = 0;
    n_fail  = 0;
    hist    = 4'b0000;
    clr     = 1'b1;
    x       = 1'b0;

    // Reset with x toggling, then the main stream with known pulses after
    // bits 5, 8 and 16, then five trailing zeros.
    main_bits  = "0101101100101011";
    pulse_bits = "0000100100000001";
    add_vec(1'b1, 1'b1, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < main_bits.len(); i++) begin
      add_vec(1'b0, (main_bits[i] == 8'h31), (pulse_bits[i] == 8'h31));
    end
    for (int i = 0; i < 5; i++) begin
      add_vec(1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].x, vecs[i].z_exp, $sformatf("vec%0d", i));
    end

    // Near misses, each separated by a clear.
    drive_model(1'b1, 1'b0, "nm_clr_a");
    send_str("10010000", "nm_1001");
    drive_model(1'b1, 1'b0, "nm_clr_b");
    send_str("10100000", "nm_1010");
    drive_model(1'b1, 1'b0, "nm_clr_c");
    send_str("01100000", "nm_0110");
    drive_model(1'b1, 1'b0, "nm_clr_d");
    send_str("11010000", "nm_1101");

    // Corner prefixes that still detect.
    drive_model(1'b1, 1'b0, "cc_clr_a");
    send_str("1101100", "cc_11011");
    drive_model(1'b1, 1'b0, "cc_clr_b");
    send_str("10101100", "cc_101011");

    // Overlap chain, then extra ones that must not pulse.
    drive_model(1'b1, 1'b0, "ov_clr");
    send_str("1011011011", "ov_chain");
    send_str("11", "ov_tail");

    // Clear mid-sequence after 101 breaks the match.
    drive_model(1'b1, 1'b0, "mid_clr0");
    send_str("101", "mid_pre");
    drive_model(1'b1, 1'b1, "mid_clr");
    send_str("1", "mid_post");
    send_str("0110", "mid_resume");

    // Clear asserted while z is high, in S4.
    drive_model(1'b1, 1'b0, "s4_clr0");
    send_str("1011", "s4_pre");
    drive_model(1'b1, 1'b1, "s4_clr");
    send_str("1", "s4_one");
    send_str("10110", "s4_again");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
